// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: FSM states, bypass tracker entry, flush counter width.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BUSY = 2'd2
  } fsm_st_t;

  // Tracker entries hold the widest supported register index; narrower indices are zero-extended.
  localparam int TRK_AW = 8;
  localparam int FCNT_W = 3;

  typedef struct packed {
    logic [TRK_AW-1:0] dst;
    logic              is_load;
  } trk_ent_t;

endpackage

// File: rtl/miss_keep.sv
// Cache-miss keeper: holds a stall from the miss cycle until the arrival cycle (arrival cycle itself is stall-free).
module miss_keep
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic i_miss,
  input  logic i_arrival,
  output logic o_st
);

  fsm_st_t r_state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_miss && !i_arrival) r_state <= ST_WAIT;
        ST_WAIT: if (i_arrival) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_st = !i_arrival && (i_miss || (r_state == ST_WAIT));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: bypass selects, load-use/miss/MDU stalls, jump and mispredict flush.
// Define HAZARD_STAT_EN to build the saturating stall/flush cycle counters; otherwise they read 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FWD_DEPTH  = 2,
  parameter int REG_AW     = 5,
  parameter int FLUSH_JMP  = 2,
  parameter int FLUSH_MISP = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [REG_AW-1:0]    dec_dst,
  input  logic                 dec_dst_en,
  input  logic                 dec_is_load,
  input  logic                 dec_is_j,
  input  logic                 dec_is_b,
  input  logic                 dec_pre_taken,
  input  logic [REG_AW-1:0]    dec_src1,
  input  logic [REG_AW-1:0]    dec_src2,
  input  logic                 dec_is_mdu,
  input  logic                 ex_real_taken,
  input  logic                 mdu_fin,
  input  logic                 f_cmiss,
  input  logic                 f_arrival,
  input  logic                 m_cmiss,
  input  logic                 m_arrival,
  output logic [FWD_DEPTH-1:0] src1_sel,
  output logic [FWD_DEPTH-1:0] src2_sel,
  output logic                 fd_st,
  output logic                 de_st,
  output logic                 em_st,
  output logic                 mw_st,
  output logic                 flush_o,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
);

  trk_ent_t [FWD_DEPTH-1:0] r_trk;
  fsm_st_t                  r_mdu;
  logic                     r_bpend;
  logic                     r_pred;
  logic [FCNT_W-1:0]        r_fcnt;

  logic              w_i_st, w_d_st, w_mdu_st, w_ld_haz;
  logic              w_misp, w_flush, w_de_st;
  logic [TRK_AW-1:0] w_src1_x, w_src2_x;
  logic              w_unused;

  assign w_src1_x = TRK_AW'(dec_src1);
  assign w_src2_x = TRK_AW'(dec_src2);
  assign w_unused = r_trk[FWD_DEPTH-1].is_load;

  miss_keep u_imiss (.clk(clk), .rstn(rstn), .i_miss(f_cmiss), .i_arrival(f_arrival), .o_st(w_i_st));
  miss_keep u_dmiss (.clk(clk), .rstn(rstn), .i_miss(m_cmiss), .i_arrival(m_arrival), .o_st(w_d_st));

  assign w_misp   = r_bpend && (r_pred != ex_real_taken);
  assign w_flush  = w_misp || (r_fcnt != '0);
  assign w_ld_haz = r_trk[0].is_load && (r_trk[0].dst != '0) &&
                    ((r_trk[0].dst == w_src1_x) || (r_trk[0].dst == w_src2_x));
  assign w_mdu_st = !(mdu_fin || w_flush) && (dec_is_mdu || (r_mdu == ST_BUSY));
  assign w_de_st  = w_ld_haz || w_d_st || w_mdu_st;

  assign fd_st   = w_i_st || w_de_st;
  assign de_st   = w_de_st;
  assign em_st   = w_d_st;
  assign mw_st   = w_d_st;
  assign flush_o = w_flush;

  // Descending scan so the youngest matching stage overwrites older ones.
  always_comb begin
    src1_sel = '0;
    src2_sel = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if ((dec_src1 != '0) && (r_trk[k].dst == w_src1_x)) begin
        src1_sel    = '0;
        src1_sel[k] = 1'b1;
      end
      if ((dec_src2 != '0) && (r_trk[k].dst == w_src2_x)) begin
        src2_sel    = '0;
        src2_sel[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_trk <= '0;
    end else if (!w_d_st) begin
      for (int k = 1; k < FWD_DEPTH; k++) r_trk[k] <= r_trk[k-1];
      if (w_de_st || w_flush || !dec_dst_en) begin
        r_trk[0] <= '0;
      end else begin
        r_trk[0].dst     <= TRK_AW'(dec_dst);
        r_trk[0].is_load <= dec_is_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mdu <= ST_IDLE;
    end else begin
      case (r_mdu)
        ST_IDLE: if (dec_is_mdu && !w_flush && !mdu_fin) r_mdu <= ST_BUSY;
        ST_BUSY: if (mdu_fin) r_mdu <= ST_IDLE;
        default: r_mdu <= ST_IDLE;
      endcase
    end
  end

  // A mispredict resolving right after a jump replaces the jump's remaining flush count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bpend <= 1'b0;
      r_pred  <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      r_bpend <= dec_is_b && !w_flush && !w_de_st;
      r_pred  <= dec_pre_taken;
      if (w_misp)                                r_fcnt <= FCNT_W'(FLUSH_MISP - 1);
      else if (dec_is_j && !w_flush && !w_de_st) r_fcnt <= FCNT_W'(FLUSH_JMP);
      else if (r_fcnt != '0)                     r_fcnt <= r_fcnt - 1'b1;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (fd_st && (r_stall_cnt != '1))   r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_hazard_ctrl;

  localparam int FD = 2;
  localparam int AW = 5;
  localparam int FJ = 2;
  localparam int FM = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] dec_dst, dec_src1, dec_src2;
  logic          dec_dst_en, dec_is_load, dec_is_j, dec_is_b, dec_pre_taken, dec_is_mdu;
  logic          ex_real_taken, mdu_fin, f_cmiss, f_arrival, m_cmiss, m_arrival;
  logic [FD-1:0] src1_sel, src2_sel;
  logic          fd_st, de_st, em_st, mw_st, flush_o;
  logic [31:0]   stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.FWD_DEPTH(FD), .REG_AW(AW), .FLUSH_JMP(FJ), .FLUSH_MISP(FM)) dut (
    .clk(clk), .rstn(rstn),
    .dec_dst(dec_dst), .dec_dst_en(dec_dst_en), .dec_is_load(dec_is_load),
    .dec_is_j(dec_is_j), .dec_is_b(dec_is_b), .dec_pre_taken(dec_pre_taken),
    .dec_src1(dec_src1), .dec_src2(dec_src2), .dec_is_mdu(dec_is_mdu),
    .ex_real_taken(ex_real_taken), .mdu_fin(mdu_fin),
    .f_cmiss(f_cmiss), .f_arrival(f_arrival), .m_cmiss(m_cmiss), .m_arrival(m_arrival),
    .src1_sel(src1_sel), .src2_sel(src2_sel),
    .fd_st(fd_st), .de_st(de_st), .em_st(em_st), .mw_st(mw_st), .flush_o(flush_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pipeline occupancy as a queue (front = youngest), misses/MDU as flags,
  // flush as "cycles of flush still owed".
  typedef struct { int dst; bit ld; } ent_t;
  typedef struct { int s1; int s2; bit fd; bit de; bit em; bit mw; bit fl; bit misp; } exp_t;

  ent_t   m_trk[$];
  bit     m_iwait, m_dwait, m_mbusy, m_bpend, m_pred;
  int     m_fleft;
  longint m_scnt, m_fcnt;

  logic [FD-1:0] c_s1, c_s2;
  logic          c_fd, c_de, c_em, c_mw, c_fl;
  logic [31:0]   c_scnt;

  function automatic void model_reset();
    ent_t z;
    z = '{0, 1'b0};
    m_trk = {};
    for (int k = 0; k < FD; k++) m_trk.push_back(z);
    m_iwait = 0; m_dwait = 0; m_mbusy = 0; m_bpend = 0; m_pred = 0;
    m_fleft = 0; m_scnt = 0; m_fcnt = 0;
  endfunction

  function automatic int pick(int src);
    for (int k = 0; k < FD; k++)
      if (src != 0 && m_trk[k].dst == src) return 1 << k;
    return 0;
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    bit ist, dst, mst, ld;
    e.misp = m_bpend && (m_pred != ex_real_taken);
    e.fl   = e.misp || (m_fleft > 0);
    ld     = m_trk[0].ld && m_trk[0].dst != 0 &&
             (m_trk[0].dst == int'(dec_src1) || m_trk[0].dst == int'(dec_src2));
    ist    = !f_arrival && (f_cmiss || m_iwait);
    dst    = !m_arrival && (m_cmiss || m_dwait);
    mst    = !(mdu_fin || e.fl) && (dec_is_mdu || m_mbusy);
    e.de   = ld || dst || mst;
    e.fd   = e.de || ist;
    e.em   = dst;
    e.mw   = dst;
    e.s1   = pick(int'(dec_src1));
    e.s2   = pick(int'(dec_src2));
    return e;
  endfunction

  function automatic void model_update(exp_t e);
    ent_t n;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (!e.em) begin
      n = '{0, 1'b0};
      if (!e.de && !e.fl && dec_dst_en) n = '{int'(dec_dst), dec_is_load};
      m_trk.push_front(n);
      void'(m_trk.pop_back());
    end
    m_iwait = m_iwait ? !f_arrival : (f_cmiss && !f_arrival);
    m_dwait = m_dwait ? !m_arrival : (m_cmiss && !m_arrival);
    m_mbusy = m_mbusy ? !mdu_fin : (dec_is_mdu && !e.fl && !mdu_fin);
    m_bpend = dec_is_b && !e.fl && !e.de;
    m_pred  = dec_pre_taken;
    if (e.misp)                           m_fleft = FM - 1;
    else if (dec_is_j && !e.fl && !e.de)  m_fleft = FJ;
    else if (m_fleft > 0)                 m_fleft--;
    if (e.fd) m_scnt++;
    if (e.fl) m_fcnt++;
  endfunction

  task automatic step();
    exp_t e;
    logic [31:0] es, ef;
    @(negedge clk);
    e = model_eval();
`ifdef HAZARD_STAT_EN
    es = 32'(m_scnt);
    ef = 32'(m_fcnt);
`else
    es = 32'd0;
    ef = 32'd0;
`endif
    chk("src1_sel", 32'(src1_sel), 32'(e.s1));
    chk("src2_sel", 32'(src2_sel), 32'(e.s2));
    chk("fd_st", 32'(fd_st), 32'(e.fd));
    chk("de_st", 32'(de_st), 32'(e.de));
    chk("em_st", 32'(em_st), 32'(e.em));
    chk("mw_st", 32'(mw_st), 32'(e.mw));
    chk("flush_o", 32'(flush_o), 32'(e.fl));
    chk("stall_cnt", stall_cnt, es);
    chk("flush_cnt", flush_cnt, ef);
    c_s1 = src1_sel; c_s2 = src2_sel; c_fd = fd_st; c_de = de_st;
    c_em = em_st; c_mw = mw_st; c_fl = flush_o; c_scnt = stall_cnt;
    @(posedge clk);
    model_update(e);
    #1;
  endtask

  task automatic idle();
    dec_dst = '0; dec_dst_en = 0; dec_is_load = 0; dec_is_j = 0; dec_is_b = 0;
    dec_pre_taken = 0; dec_src1 = '0; dec_src2 = '0; dec_is_mdu = 0;
    ex_real_taken = 0; mdu_fin = 0; f_cmiss = 0; f_arrival = 0; m_cmiss = 0; m_arrival = 0;
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // reset state
    step();
    chk("rst_fd", 32'(c_fd), 32'd0);
    chk("rst_flush", 32'(c_fl), 32'd0);
    chk("rst_scnt", c_scnt, 32'd0);

    // forwarding: producer x5, consumer one and two cycles later, x0 consumer
    idle(); dec_dst = 5'd5; dec_dst_en = 1; step();
    idle(); dec_src1 = 5'd5; dec_src2 = 5'd5; step();
    chk("fwd_s1_stage1", 32'(c_s1), 32'h1);
    chk("fwd_s2_stage1", 32'(c_s2), 32'h1);
    idle(); dec_src1 = 5'd5; step();
    chk("fwd_s1_stage2", 32'(c_s1), 32'h2);
    idle(); dec_dst = 5'd0; dec_dst_en = 1; step();
    idle(); step();
    chk("fwd_x0", 32'(c_s1), 32'h0);

    // load-use: one-cycle bubble
    idle(); dec_dst = 5'd7; dec_dst_en = 1; dec_is_load = 1; step();
    idle(); dec_src1 = 5'd7; dec_dst = 5'd8; dec_dst_en = 1; step();
    chk("ldu_fd", 32'(c_fd), 32'd1);
    chk("ldu_de", 32'(c_de), 32'd1);
    chk("ldu_sel", 32'(c_s1), 32'h1);
    step();
    chk("ldu_fd_after", 32'(c_fd), 32'd0);
    chk("ldu_de_after", 32'(c_de), 32'd0);

    // mispredict: two flush cycles; correct prediction: none
    idle(); dec_is_b = 1; dec_pre_taken = 0; step();
    chk("misp_c0", 32'(c_fl), 32'd0);
    idle(); ex_real_taken = 1; step();
    chk("misp_c1", 32'(c_fl), 32'd1);
    idle(); step();
    chk("misp_c2", 32'(c_fl), 32'd1);
    idle(); step();
    chk("misp_c3", 32'(c_fl), 32'd0);
    idle(); dec_is_b = 1; dec_pre_taken = 1; step();
    idle(); ex_real_taken = 1; step();
    chk("bok_c1", 32'(c_fl), 32'd0);
    idle(); step();
    chk("bok_c2", 32'(c_fl), 32'd0);

    // jump, with a second jump inside the flush window
    idle(); dec_is_j = 1; step();
    chk("jmp_c0", 32'(c_fl), 32'd0);
    idle(); dec_is_j = 1; step();
    chk("jmp_c1", 32'(c_fl), 32'd1);
    idle(); step();
    chk("jmp_c2", 32'(c_fl), 32'd1);
    idle(); step();
    chk("jmp_c3", 32'(c_fl), 32'd0);

    // D-miss for four cycles; tracker must hold x3 in stage 1
    idle(); dec_dst = 5'd3; dec_dst_en = 1; step();
    for (int i = 0; i < 4; i++) begin
      idle(); dec_src1 = 5'd3; dec_dst = 5'd9; dec_dst_en = 1; m_cmiss = (i == 0);
      step();
      chk("dmiss_fd", 32'(c_fd), 32'd1);
      chk("dmiss_de", 32'(c_de), 32'd1);
      chk("dmiss_em", 32'(c_em), 32'd1);
      chk("dmiss_mw", 32'(c_mw), 32'd1);
      chk("dmiss_trk", 32'(c_s1), 32'h1);
    end
    idle(); dec_src1 = 5'd3; m_arrival = 1; step();
    chk("dmiss_end_em", 32'(c_em), 32'd0);
    chk("dmiss_end_trk", 32'(c_s1), 32'h1);

    // MDU busy, then reset mid-operation
    idle(); dec_is_mdu = 1; step();
    chk("mdu_c0", 32'(c_fd), 32'd1);
    step();
    chk("mdu_busy", 32'(c_de), 32'd1);
    rstn = 1'b0; step();
    rstn = 1'b1; idle(); step();
    chk("mdu_rst_fd", 32'(c_fd), 32'd0);
    chk("mdu_rst_de", 32'(c_de), 32'd0);
    chk("mdu_rst_scnt", c_scnt, 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rstn          = ($urandom_range(199, 0) != 0);
      dec_dst       = AW'($urandom_range(7, 0));
      dec_dst_en    = ($urandom_range(3, 0) != 0);
      dec_is_load   = ($urandom_range(2, 0) == 0);
      dec_is_j      = ($urandom_range(9, 0) == 0);
      dec_is_b      = ($urandom_range(3, 0) == 0);
      dec_pre_taken = 1'($urandom_range(1, 0));
      dec_src1      = AW'($urandom_range(7, 0));
      dec_src2      = AW'($urandom_range(7, 0));
      dec_is_mdu    = ($urandom_range(11, 0) == 0);
      ex_real_taken = 1'($urandom_range(1, 0));
      mdu_fin       = !dec_is_mdu && ($urandom_range(3, 0) == 0);
      f_cmiss       = ($urandom_range(15, 0) == 0);
      f_arrival     = ($urandom_range(3, 0) == 0);
      m_cmiss       = ($urandom_range(19, 0) == 0);
      m_arrival     = ($urandom_range(3, 0) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
